// File: rtl/cplx_stream_loader.sv
// Strided TCDM loader: fetches complex samples (packed or word-interleaved) and
// splits them into independent real/imag valid/ready streams.
module cplx_stream_loader #(
  parameter int unsigned DW         = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [31:0]      stride_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             tcdm_req_o,
  input  logic             tcdm_gnt_i,
  output logic [31:0]      tcdm_add_o,
  output logic             tcdm_wen_o,
  input  logic [31:0]      tcdm_r_data_i,
  input  logic             tcdm_r_valid_i,
  output logic             re_valid_o,
  input  logic             re_ready_i,
  output logic [DW-1:0]    re_data_o,
  output logic             im_valid_o,
  input  logic             im_ready_i,
  output logic [DW-1:0]    im_data_o
);

  localparam int unsigned   AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH = (AW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]    r_addr, r_stride;
  logic           r_mode, r_re_sent, r_im_sent, r_discard, r_done;
  logic [LEN_W:0] r_words, r_wcnt;
  logic [31:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_rd, r_wr, w_rd1;
  logic [AW:0]    r_cnt, r_out, w_pop_n, w_cnt_nxt, w_out_nxt;
  logic           w_gnt, w_push, w_avail, w_re_done, w_im_done, w_pop;
  logic           w_last_gnt, w_start_run, w_start_zero;
  logic [DW-1:0]  w_im_pk;

  assign w_gnt        = tcdm_req_o & tcdm_gnt_i;
  // r_discard masks the response belonging to a grant seen in the clear cycle
  assign w_push       = tcdm_r_valid_i & ~r_discard & ~clear_i;
  assign w_start_run  = start_i & (r_state == S_IDLE) & ~clear_i & (len_i != '0);
  assign w_start_zero = start_i & (r_state == S_IDLE) & ~clear_i & (len_i == '0);
  assign w_last_gnt   = (r_wcnt == r_words - (LEN_W+1)'(1));
  assign w_avail      = r_mode ? (r_cnt > (AW+1)'(1)) : (r_cnt != '0);
  assign w_re_done    = r_re_sent | (re_valid_o & re_ready_i);
  assign w_im_done    = r_im_sent | (im_valid_o & im_ready_i);
  assign w_pop        = w_avail & w_re_done & w_im_done;
  assign w_pop_n      = !w_pop ? '0 : (r_mode ? (AW+1)'(2) : (AW+1)'(1));
  assign w_cnt_nxt    = r_cnt + (AW+1)'(w_push) - w_pop_n;
  assign w_out_nxt    = r_out + (AW+1)'(w_gnt) - (AW+1)'(w_push);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        r_state <= S_IDLE;
    else if (clear_i) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_run) w_state_nxt = S_RUN;
      S_RUN:   if (w_gnt && w_last_gnt) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_cnt_nxt == '0 && w_out_nxt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Credit gate: words in FIFO plus words in flight never exceed the FIFO depth
  always_comb begin
    tcdm_req_o = (r_state == S_RUN) & ~clear_i & (({1'b0, r_cnt} + {1'b0, r_out}) < DEPTH);
    busy_o     = (r_state != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr <= '0; r_stride <= '0; r_mode <= 1'b0; r_words <= '0; r_wcnt <= '0;
      r_rd <= '0; r_wr <= '0; r_cnt <= '0; r_out <= '0;
      r_re_sent <= 1'b0; r_im_sent <= 1'b0; r_discard <= 1'b1; r_done <= 1'b0;
    end else if (clear_i) begin
      r_addr <= '0; r_wcnt <= '0;
      r_rd <= '0; r_wr <= '0; r_cnt <= '0; r_out <= '0;
      r_re_sent <= 1'b0; r_im_sent <= 1'b0; r_discard <= 1'b1; r_done <= 1'b0;
    end else begin
      r_discard <= 1'b0;
      r_done    <= w_start_zero | ((r_state == S_DRAIN) & (w_state_nxt == S_IDLE));
      if (w_start_run) begin
        r_addr   <= base_addr_i;
        r_stride <= stride_i;
        r_mode   <= mode_i;
        r_words  <= mode_i ? {len_i, 1'b0} : {1'b0, len_i};
        r_wcnt   <= '0;
      end else if (w_gnt) begin
        r_addr <= r_addr + r_stride;
        r_wcnt <= r_wcnt + (LEN_W+1)'(1);
      end
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd  <= r_rd + w_pop_n[AW-1:0];
      r_cnt <= w_cnt_nxt;
      r_out <= w_out_nxt;
      if (w_pop) begin
        r_re_sent <= 1'b0;
        r_im_sent <= 1'b0;
      end else begin
        if (re_valid_o & re_ready_i) r_re_sent <= 1'b1;
        if (im_valid_o & im_ready_i) r_im_sent <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= tcdm_r_data_i;
  end

  assign w_rd1 = r_rd + AW'(1);

  generate
    if (DW <= 16) begin : g_packed
      assign w_im_pk = r_mem[r_rd][2*DW-1:DW];
    end else begin : g_wide
      assign w_im_pk = '0;
    end
  endgenerate

  assign re_valid_o = w_avail & ~r_re_sent;
  assign im_valid_o = w_avail & ~r_im_sent;
  assign re_data_o  = w_avail ? r_mem[r_rd][DW-1:0] : '0;
  assign im_data_o  = !w_avail ? '0 : (r_mode ? r_mem[w_rd1][DW-1:0] : w_im_pk);
  assign tcdm_add_o = r_addr;
  assign tcdm_wen_o = 1'b1;
  assign done_o     = r_done;

endmodule

// File: tb/tb_cplx_stream_loader.sv
// Randomised bench for cplx_stream_loader: TCDM memory responder plus a
// queue-based sample model checked every cycle, and literal directed cases.
module tb_cplx_stream_loader;
  localparam int DW = 16, FD = 4, LW = 16;

  logic clk_i, rst_i, clear_i, start_i, mode_i;
  logic [31:0] base_addr_i, stride_i, tcdm_add_o, tcdm_r_data_i;
  logic [LW-1:0] len_i;
  logic busy_o, done_o, tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic re_valid_o, re_ready_i, im_valid_o, im_ready_i;
  logic [DW-1:0] re_data_o, im_data_o;

  cplx_stream_loader #(.DW(DW), .FIFO_DEPTH(FD), .LEN_W(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .len_i(len_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_r_data_i(tcdm_r_data_i),
    .tcdm_r_valid_i(tcdm_r_valid_i), .re_valid_o(re_valid_o), .re_ready_i(re_ready_i),
    .re_data_o(re_data_o), .im_valid_o(im_valid_o), .im_ready_i(im_ready_i),
    .im_data_o(im_data_o));

  always #5 clk_i = ~clk_i;

  int n_pass = 0, n_total = 0, cyc = 0;
  int gnt_pct, rre_pct, rim_pct;
  logic [31:0] mem [logic [31:0]];
  logic [DW-1:0] exp_re[$], exp_im[$], obs_re[$], obs_im[$];
  logic [31:0] exp_addr[$], obs_addr[$];
  logic m_busy, exp_done, resp_pend, xfer_done;
  logic [31:0] resp_data, a0, w0, w1, prev_add;
  logic [DW-1:0] prev_re, prev_im;
  logic prev_req_wait, prev_re_pend, prev_im_pend;
  int m_wps, nw, held, n_re, n_im, n_gnt, n_stall, done_cnt, first_vld, done_cyc, c0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    n_total++;
    $display("FAIL %s: bound expired without completion (t=%0t)", nm, $time);
  endtask

  // Memory responder and random ready/grant generation
  initial begin
    forever begin
      @(posedge clk_i); #2;
      tcdm_gnt_i     = ($urandom_range(0, 99) < gnt_pct);
      re_ready_i     = ($urandom_range(0, 99) < rre_pct);
      im_ready_i     = ($urandom_range(0, 99) < rim_pct);
      tcdm_r_valid_i = resp_pend;
      tcdm_r_data_i  = resp_pend ? resp_data : $urandom;
      resp_pend      = 1'b0;
    end
  end

  // Per-cycle compare against the sample/address queues
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_re.delete(); exp_im.delete(); exp_addr.delete();
      m_busy = 0; exp_done = 0; resp_pend = 0;
      prev_req_wait = 0; prev_re_pend = 0; prev_im_pend = 0;
    end else begin
      chk("wen", 32'(tcdm_wen_o), 32'd1);
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("done", 32'(done_o), 32'(exp_done));
      if (done_o) begin done_cnt++; xfer_done = 1; done_cyc = cyc; end
      if (!m_busy) chk("idle_quiet", 32'({tcdm_req_o, re_valid_o, im_valid_o}), 32'd0);
      if (prev_req_wait && !clear_i) begin
        chk("req_hold", 32'(tcdm_req_o), 32'd1);
        chk("addr_hold", tcdm_add_o, prev_add);
      end
      if (prev_re_pend) chk("re_hold", 32'({re_valid_o, re_data_o}), 32'({1'b1, prev_re}));
      if (prev_im_pend) chk("im_hold", 32'({im_valid_o, im_data_o}), 32'({1'b1, prev_im}));
      if (tcdm_req_o) begin
        if (exp_addr.size() == 0) fail_now("req_spurious");
        else chk("addr", tcdm_add_o, exp_addr[0]);
      end
      if ((re_valid_o || im_valid_o) && first_vld < 0) first_vld = cyc;
      if (re_valid_o && re_ready_i) begin
        if (exp_re.size() == 0) fail_now("re_spurious");
        else begin chk("re_data", 32'(re_data_o), 32'(exp_re.pop_front())); n_re++; obs_re.push_back(re_data_o); end
      end
      if (im_valid_o && im_ready_i) begin
        if (exp_im.size() == 0) fail_now("im_spurious");
        else begin chk("im_data", 32'(im_data_o), 32'(exp_im.pop_front())); n_im++; obs_im.push_back(im_data_o); end
      end
      if (tcdm_req_o && !tcdm_gnt_i) n_stall++;
      if (tcdm_req_o && tcdm_gnt_i) begin
        if (exp_addr.size() != 0) void'(exp_addr.pop_front());
        obs_addr.push_back(tcdm_add_o);
        n_gnt++;
        resp_pend = 1; resp_data = memrd(tcdm_add_o);
        held = n_gnt - ((n_re < n_im) ? n_re : n_im) * m_wps;
        chk("outstanding_bound", 32'(held <= FD), 32'd1);
      end else if (clear_i && tcdm_gnt_i) begin
        resp_pend = 1; resp_data = 32'hDEAD_BEEF;
      end
      prev_req_wait = tcdm_req_o & ~tcdm_gnt_i & ~clear_i;
      prev_add      = tcdm_add_o;
      prev_re_pend  = re_valid_o & ~re_ready_i & ~clear_i;
      prev_im_pend  = im_valid_o & ~im_ready_i & ~clear_i;
      prev_re = re_data_o; prev_im = im_data_o;
      exp_done = 0;
      if (clear_i) begin
        exp_re.delete(); exp_im.delete(); exp_addr.delete(); m_busy = 0;
      end else if (m_busy && exp_re.size() == 0 && exp_im.size() == 0 && exp_addr.size() == 0) begin
        m_busy = 0; exp_done = 1;
      end else if (!m_busy && start_i) begin
        if (len_i == 0) exp_done = 1;
        else begin
          m_busy = 1; n_re = 0; n_im = 0; n_gnt = 0;
          m_wps = mode_i ? 2 : 1;
          nw = int'(len_i) * m_wps;
          for (int k = 0; k < nw; k++) begin
            a0 = base_addr_i + stride_i * 32'(k);
            exp_addr.push_back(a0);
          end
          for (int s = 0; s < int'(len_i); s++) begin
            if (!mode_i) begin
              w0 = memrd(exp_addr[s]);
              exp_re.push_back(w0[15:0]); exp_im.push_back(w0[31:16]);
            end else begin
              w0 = memrd(exp_addr[2*s]); w1 = memrd(exp_addr[2*s+1]);
              exp_re.push_back(w0[15:0]); exp_im.push_back(w1[15:0]);
            end
          end
        end
      end
    end
  end

  task automatic do_start(input logic m, input logic [31:0] b, input logic [31:0] s, input logic [LW-1:0] l);
    @(posedge clk_i); #1;
    mode_i = m; base_addr_i = b; stride_i = s; len_i = l; start_i = 1;
    c0 = cyc; done_cnt = 0; xfer_done = 0; first_vld = -1; n_stall = 0;
    obs_re.delete(); obs_im.delete(); obs_addr.delete();
    @(posedge clk_i); #1;
    start_i = 0;
  endtask

  task automatic pulse_start(input logic m, input logic [LW-1:0] l);
    @(posedge clk_i); #1;
    mode_i = m; len_i = l; start_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    for (int i = 0; i < maxc && !xfer_done; i++) @(posedge clk_i);
    if (!xfer_done) fail_now(nm);
    @(posedge clk_i);
  endtask

  initial begin
    logic [31:0] rb, rs;
    logic [DW-1:0] t1_re[4], t1_im[4];
    clk_i = 0; rst_i = 1; clear_i = 0; start_i = 0; mode_i = 0;
    base_addr_i = 0; stride_i = 0; len_i = 0;
    tcdm_gnt_i = 0; tcdm_r_valid_i = 0; tcdm_r_data_i = 0; re_ready_i = 0; im_ready_i = 0;
    gnt_pct = 100; rre_pct = 100; rim_pct = 100; resp_pend = 0;
    first_vld = -1; done_cnt = 0; xfer_done = 0; n_stall = 0; m_wps = 1;
    n_re = 0; n_im = 0; n_gnt = 0;
    #2;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_req", 32'(tcdm_req_o), 32'd0);
    chk("rst_valids", 32'({re_valid_o, im_valid_o}), 32'd0);
    chk("rst_add", tcdm_add_o, 32'd0);
    chk("rst_data", 32'({re_data_o, im_data_o}), 32'd0);
    chk("rst_wen", 32'(tcdm_wen_o), 32'd1);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;

    // Packed, literal expectations
    for (int k = 0; k < 4; k++) mem[32'h100 + 32'(4*k)] = {16'(2*k+2), 16'(2*k+1)};
    t1_re = '{16'd1, 16'd3, 16'd5, 16'd7};
    t1_im = '{16'd2, 16'd4, 16'd6, 16'd8};
    do_start(1'b0, 32'h100, 32'd4, 16'd4);
    wait_done("t1_timeout", 100);
    chk("t1_first_valid", 32'(first_vld - c0), 32'd3);
    chk("t1_done_cycle", 32'(done_cyc - c0), 32'd7);
    chk("t1_done_count", 32'(done_cnt), 32'd1);
    chk("t1_samples", 32'(obs_re.size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_re.size(); k++) begin
      chk("t1_re", 32'(obs_re[k]), 32'(t1_re[k]));
      chk("t1_im", 32'(obs_im[k]), 32'(t1_im[k]));
      chk("t1_addr", obs_addr[k], 32'h100 + 32'(4*k));
    end

    // Interleaved, stride 8
    do_start(1'b1, 32'h2000, 32'd8, 16'd3);
    wait_done("t2_timeout", 200);
    chk("t2_grants", 32'(obs_addr.size()), 32'd6);
    for (int k = 0; k < 6 && k < obs_addr.size(); k++) chk("t2_addr", obs_addr[k], 32'h2000 + 32'(8*k));
    chk("t2_samples", 32'(obs_re.size()), 32'd3);
    chk("t2_done_count", 32'(done_cnt), 32'd1);

    // Imag backpressure for well over 10 cycles
    rim_pct = 0;
    do_start(1'b0, 32'h3000, 32'd4, 16'd8);
    repeat (13) @(posedge clk_i);
    chk("bp_re_once", 32'(n_re), 32'd1);
    chk("bp_im_none", 32'(n_im), 32'd0);
    rim_pct = 100;
    wait_done("bp_timeout", 200);
    chk("bp_all_samples", 32'({n_re[15:0], n_im[15:0]}), {16'd8, 16'd8});

    // Grant stall
    do_start(1'b0, 32'h4000, 32'd4, 16'd6);
    @(posedge clk_i); #1 gnt_pct = 0;
    repeat (6) @(posedge clk_i);
    #1 gnt_pct = 100;
    wait_done("stall_timeout", 200);
    chk("stall_cycles", 32'(n_stall >= 5), 32'd1);
    chk("stall_grants", 32'(n_gnt), 32'd6);

    // Clear in a grant cycle, then a fresh len=2 transfer
    do_start(1'b0, 32'h5000, 32'd4, 16'd6);
    repeat (2) @(posedge clk_i);
    #1 clear_i = 1;
    @(posedge clk_i); #1 clear_i = 0;
    repeat (3) @(posedge clk_i);
    chk("clr_busy", 32'(busy_o), 32'd0);
    chk("clr_no_done", 32'(done_cnt), 32'd0);
    do_start(1'b0, 32'h5100, 32'd4, 16'd2);
    wait_done("clr_timeout", 200);
    chk("clr_samples", 32'({n_re[15:0], n_im[15:0]}), {16'd2, 16'd2});

    // len = 0, then start while busy
    do_start(1'b0, 32'h6000, 32'd4, 16'd0);
    wait_done("len0_timeout", 20);
    chk("len0_done_cycle", 32'(done_cyc - c0), 32'd1);
    do_start(1'b0, 32'h6000, 32'd4, 16'd5);
    pulse_start(1'b1, 16'd9);
    wait_done("ign_timeout", 200);
    chk("ign_samples", 32'(n_re), 32'd5);
    chk("ign_done_count", 32'(done_cnt), 32'd1);

    // Randomised transfers
    for (int it = 0; it < 24; it++) begin
      gnt_pct = $urandom_range(30, 100);
      rre_pct = $urandom_range(30, 100);
      rim_pct = $urandom_range(30, 100);
      rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8)) * 4;
      do_start(1'($urandom_range(0, 1)), rb, rs, 16'($urandom_range(1, 10)));
      if (it % 3 == 0) pulse_start(1'b0, 16'd3);
      wait_done("rand_timeout", 2000);
      chk("rand_done_count", 32'(done_cnt), 32'd1);
    end

    repeat (3) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
